// File: rtl/ipv4_header_inserter_pkg.sv
// Shared types for the IPv4 header inserter: FSM states, header field bundle
// and the header word selector used when streaming the 20-byte header.
package ipv4_header_inserter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CSUM    = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  localparam int IPV4_HDR_WORDS = 5;

  typedef struct packed {
    logic [7:0]  version;
    logic [7:0]  service_type;
    logic [15:0] length;
    logic [15:0] identification;
    logic [15:0] flags_and_fragment;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  // Header word idx of the 20-byte header, first byte in [31:24].
  function automatic logic [31:0] hdr_word(input ipv4_hdr_t h,
                                           input logic [15:0] csum,
                                           input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {h.version, h.service_type, h.length};
      3'd1:    w = {h.identification, h.flags_and_fragment};
      3'd2:    w = {h.ttl, h.protocol, csum};
      3'd3:    w = h.src_ip;
      3'd4:    w = h.dst_ip;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ipv4_checksum_calculator.sv
// Combinational IPv4 header checksum: one's-complement of the one's-complement
// sum of the header 16-bit words, checksum field taken as zero.
module ipv4_checksum_calculator (
  input  logic [7:0]  version_i,
  input  logic [7:0]  service_type_i,
  input  logic [15:0] length_i,
  input  logic [15:0] identification_i,
  input  logic [15:0] flags_and_fragment_i,
  input  logic [7:0]  ttl_i,
  input  logic [7:0]  protocol_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  output logic [15:0] csum_o
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = 20'({version_i, service_type_i}) + 20'(length_i)
        + 20'(identification_i) + 20'(flags_and_fragment_i)
        + 20'({ttl_i, protocol_i})
        + 20'(src_ip_i[31:16]) + 20'(src_ip_i[15:0])
        + 20'(dst_ip_i[31:16]) + 20'(dst_ip_i[15:0]);
    // Nine words cannot carry past bit 19; two folds always settle the sum.
    fold1  = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    fold2  = fold1[15:0] + {15'b0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/ipv4_header_inserter.sv
// Prepends a 5-word IPv4 header (with registered checksum) to a 32-bit
// payload stream, then passes the payload through until its last beat.
module ipv4_header_inserter
  import ipv4_header_inserter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      HDR_VALID,
  output logic                      HDR_READY,
  input  logic [7:0]                VERSION,
  input  logic [7:0]                SERVICE_TYPE,
  input  logic [15:0]               LENGTH,
  input  logic [15:0]               IDENTIFICATION,
  input  logic [15:0]               FLAGS_AND_FRAGMENT,
  input  logic [7:0]                TTL,
  input  logic [7:0]                PROTOCOL,
  input  logic [31:0]               SRC_IP_ADDRESS,
  input  logic [31:0]               DST_IP_ADDRESS,
  input  logic                      S_TVALID,
  output logic                      S_TREADY,
  input  logic [DATA_WIDTH-1:0]     S_TDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_TKEEP,
  input  logic                      S_TLAST,
  output logic                      M_TVALID,
  input  logic                      M_TREADY,
  output logic [DATA_WIDTH-1:0]     M_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_TKEEP,
  output logic                      M_TLAST
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] LAST_IDX = 3'(IPV4_HDR_WORDS - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  ipv4_hdr_t   hdr_q, hdr_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] calc_csum;

  ipv4_checksum_calculator u_csum (
    .version_i            (hdr_q.version),
    .service_type_i       (hdr_q.service_type),
    .length_i             (hdr_q.length),
    .identification_i     (hdr_q.identification),
    .flags_and_fragment_i (hdr_q.flags_and_fragment),
    .ttl_i                (hdr_q.ttl),
    .protocol_i           (hdr_q.protocol),
    .src_ip_i             (hdr_q.src_ip),
    .dst_ip_i             (hdr_q.dst_ip),
    .csum_o               (calc_csum)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hdr_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (HDR_VALID) begin
          hdr_d = '{version:            VERSION,
                    service_type:       SERVICE_TYPE,
                    length:             LENGTH,
                    identification:     IDENTIFICATION,
                    flags_and_fragment: FLAGS_AND_FRAGMENT,
                    ttl:                TTL,
                    protocol:           PROTOCOL,
                    src_ip:             SRC_IP_ADDRESS,
                    dst_ip:             DST_IP_ADDRESS};
          state_d = CSUM;
        end
      end
      CSUM: begin
        csum_d  = calc_csum;
        idx_d   = '0;
        state_d = HDR;
      end
      HDR: begin
        if (M_TREADY) begin
          if (idx_q == LAST_IDX) begin
            state_d = PAYLOAD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PAYLOAD: begin
        if (S_TVALID && M_TREADY && S_TLAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced idle while RESET is high so a packet cut mid-flight
  // never leaks another beat, even on the cycle reset is being sampled.
  always_comb begin
    HDR_READY = 1'b0;
    S_TREADY  = 1'b0;
    M_TVALID  = 1'b0;
    M_TDATA   = '0;
    M_TKEEP   = '0;
    M_TLAST   = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE: HDR_READY = 1'b1;
        HDR: begin
          M_TVALID = 1'b1;
          M_TKEEP  = {KEEP_WIDTH{1'b1}};
          M_TDATA  = DATA_WIDTH'(hdr_word(hdr_q, csum_q, idx_q));
        end
        PAYLOAD: begin
          M_TVALID = S_TVALID;
          S_TREADY = M_TREADY;
          M_TDATA  = S_TDATA;
          M_TKEEP  = S_TKEEP;
          M_TLAST  = S_TLAST;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_header_inserter.sv
// Directed bench for ipv4_header_inserter: hand-computed header words and
// payload beats, checked with immediate assertions at each sample point.
module tb_ipv4_header_inserter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HDR_VALID;
  logic        HDR_READY;
  logic [7:0]  VERSION, SERVICE_TYPE, TTL, PROTOCOL;
  logic [15:0] LENGTH, IDENTIFICATION, FLAGS_AND_FRAGMENT;
  logic [31:0] SRC_IP_ADDRESS, DST_IP_ADDRESS;
  logic        S_TVALID, S_TREADY, S_TLAST;
  logic [31:0] S_TDATA;
  logic [3:0]  S_TKEEP;
  logic        M_TVALID, M_TREADY, M_TLAST;
  logic [31:0] M_TDATA;
  logic [3:0]  M_TKEEP;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data [16];
  logic [3:0]  exp_keep [16];
  logic        exp_last [16];
  int          n_exp;
  logic [31:0] pay_data [8];
  logic [3:0]  pay_keep [8];
  int          pay_n;

  always #5 CLK = ~CLK;

  ipv4_header_inserter dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .HDR_VALID          (HDR_VALID),
    .HDR_READY          (HDR_READY),
    .VERSION            (VERSION),
    .SERVICE_TYPE       (SERVICE_TYPE),
    .LENGTH             (LENGTH),
    .IDENTIFICATION     (IDENTIFICATION),
    .FLAGS_AND_FRAGMENT (FLAGS_AND_FRAGMENT),
    .TTL                (TTL),
    .PROTOCOL           (PROTOCOL),
    .SRC_IP_ADDRESS     (SRC_IP_ADDRESS),
    .DST_IP_ADDRESS     (DST_IP_ADDRESS),
    .S_TVALID           (S_TVALID),
    .S_TREADY           (S_TREADY),
    .S_TDATA            (S_TDATA),
    .S_TKEEP            (S_TKEEP),
    .S_TLAST            (S_TLAST),
    .M_TVALID           (M_TVALID),
    .M_TREADY           (M_TREADY),
    .M_TDATA            (M_TDATA),
    .M_TKEEP            (M_TKEEP),
    .M_TLAST            (M_TLAST)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_hdr(input int sel);
    if (sel == 1) begin
      VERSION = 8'h45; SERVICE_TYPE = 8'h00; LENGTH = 16'h0073;
      IDENTIFICATION = 16'h0000; FLAGS_AND_FRAGMENT = 16'h4000;
      TTL = 8'h40; PROTOCOL = 8'h11;
      SRC_IP_ADDRESS = 32'hC0A80001; DST_IP_ADDRESS = 32'hC0A800C7;
    end else begin
      VERSION = 8'h45; SERVICE_TYPE = 8'h00; LENGTH = 16'h001C;
      IDENTIFICATION = 16'h1234; FLAGS_AND_FRAGMENT = 16'h0000;
      TTL = 8'h80; PROTOCOL = 8'h06;
      SRC_IP_ADDRESS = 32'h0A000001; DST_IP_ADDRESS = 32'h0A000002;
    end
  endtask

  task automatic build_exp();
    n_exp = 5 + pay_n;
    for (int i = 0; i < 5; i++) begin
      exp_keep[i] = 4'hF;
      exp_last[i] = 1'b0;
    end
    for (int i = 0; i < pay_n; i++) begin
      exp_data[5+i] = pay_data[i];
      exp_keep[5+i] = pay_keep[i];
      exp_last[5+i] = (i == pay_n - 1);
    end
  endtask

  // Checksum: 4500+0073+0000+4000+4011+C0A8+0001+C0A8+00C7 = 2479C -> 479E -> ~ = B861
  task automatic load_pkt1();
    exp_data[0] = 32'h45000073; exp_data[1] = 32'h00004000; exp_data[2] = 32'h4011B861;
    exp_data[3] = 32'hC0A80001; exp_data[4] = 32'hC0A800C7;
    pay_data[0] = 32'hDEADBEEF; pay_keep[0] = 4'hF;
    pay_data[1] = 32'h01234567; pay_keep[1] = 4'hF;
    pay_data[2] = 32'h89AB0000; pay_keep[2] = 4'b1100;
    pay_n = 3;
    build_exp();
  endtask

  // Checksum: 4500+001C+1234+0000+8006+0A00+0001+0A00+0002 = EB59 -> ~ = 14A6
  task automatic load_pkt2();
    exp_data[0] = 32'h4500001C; exp_data[1] = 32'h12340000; exp_data[2] = 32'h800614A6;
    exp_data[3] = 32'h0A000001; exp_data[4] = 32'h0A000002;
    pay_data[0] = 32'hCAFEF00D; pay_keep[0] = 4'hF;
    pay_data[1] = 32'h55667788; pay_keep[1] = 4'b1110;
    pay_n = 2;
    build_exp();
  endtask

  // rdy_mode 0: M_TREADY=1; 1: toggles. gap<0: S_TVALID up from the start,
  // else S_TVALID held low for gap cycles after the header completes.
  task automatic run_pkt(input int rdy_mode, input int gap, input bit hold_next,
                         input bit expect_immediate, input int cur_sel, input int next_sel);
    int nout, npay, acc_cyc, post, t4, nb;
    bit accepted, done, prev_stall, lat_done;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    nout = 0; npay = 0; acc_cyc = -100; post = 0; t4 = -100;
    accepted = 0; done = 0; prev_stall = 0; lat_done = 0;
    prev_data = '0; prev_keep = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge CLK); #1;
      HDR_VALID = accepted ? hold_next : 1'b1;
      apply_hdr((accepted && hold_next) ? next_sel : cur_sel);
      M_TREADY = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      S_TVALID = (npay < pay_n) && ((gap < 0) || (nout >= 5 && post >= gap));
      S_TDATA  = pay_data[(npay < 8) ? npay : 0];
      S_TKEEP  = pay_keep[(npay < 8) ? npay : 0];
      S_TLAST  = (npay == pay_n - 1);
      #3;
      nb = nout;
      if (nout < 5) chk("s_tready_before_payload", {31'b0, S_TREADY}, 32'd0);
      if (prev_stall) begin
        chk("stall_data_stable", M_TDATA, prev_data);
        chk("stall_keep_stable", {28'b0, M_TKEEP}, {28'b0, prev_keep});
        chk("stall_last_stable", {31'b0, M_TLAST}, {31'b0, prev_last});
      end
      if (!accepted) begin
        if (HDR_READY) begin
          accepted = 1;
          acc_cyc = cyc;
          if (expect_immediate) chk("b2b_accept_cycle", cyc, 32'd0);
        end
      end else if (hold_next) begin
        chk("hdr_ready_busy", {31'b0, HDR_READY}, 32'd0);
      end
      if (nout >= 5 && !S_TVALID) chk("gap_m_tvalid", {31'b0, M_TVALID}, 32'd0);
      if (M_TVALID && !lat_done) begin
        lat_done = 1;
        chk("first_beat_latency", cyc, acc_cyc + 2);
      end
      if (M_TVALID && M_TREADY) begin
        chk($sformatf("beat%0d_data", nout), M_TDATA, exp_data[nout]);
        chk($sformatf("beat%0d_keep", nout), {28'b0, M_TKEEP}, {28'b0, exp_keep[nout]});
        chk($sformatf("beat%0d_last", nout), {31'b0, M_TLAST}, {31'b0, exp_last[nout]});
        if (nout == 4) t4 = cyc;
        if (nout == 5 && rdy_mode == 0 && gap < 0) chk("payload_follows_w4", cyc, t4 + 1);
        nout++;
        if (nout >= n_exp) done = 1;
      end
      if (S_TVALID && S_TREADY) npay++;
      if (nb >= 5) post++;
      prev_stall = M_TVALID && !M_TREADY;
      prev_data = M_TDATA; prev_keep = M_TKEEP; prev_last = M_TLAST;
    end
    chk("beat_count", nout, n_exp);
    $display("packet sel=%0d rdy_mode=%0d gap=%0d beats=%0d errors=%0d", cur_sel, rdy_mode, gap, nout, errors);
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    HDR_VALID = 1'b0; S_TVALID = 1'b0; M_TREADY = 1'b1;
    #3;
  endtask

  initial begin : main
    bit found;
    bit acc;
    RESET = 1'b1; HDR_VALID = 1'b0; S_TVALID = 1'b0; S_TDATA = '0; S_TKEEP = '0;
    S_TLAST = 1'b0; M_TREADY = 1'b1;
    apply_hdr(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #4;
    end
    chk("rst_hdr_ready", {31'b0, HDR_READY}, 32'd0);
    chk("rst_s_tready", {31'b0, S_TREADY}, 32'd0);
    chk("rst_m_tvalid", {31'b0, M_TVALID}, 32'd0);
    chk("rst_m_tdata", M_TDATA, 32'd0);
    chk("rst_m_tkeep", {28'b0, M_TKEEP}, 32'd0);
    chk("rst_m_tlast", {31'b0, M_TLAST}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #3;
    chk("post_rst_hdr_ready", {31'b0, HDR_READY}, 32'd1);

    // Basic packet, downstream always ready
    load_pkt1();
    run_pkt(0, 0, 0, 0, 1, 1);
    // Same packet under alternating backpressure
    run_pkt(1, 0, 0, 0, 1, 1);
    // Back-to-back with HDR_VALID held high
    load_pkt1();
    run_pkt(0, 0, 1, 0, 1, 2);
    load_pkt2();
    run_pkt(0, 0, 0, 1, 2, 2);
    // Payload offered early
    load_pkt1();
    run_pkt(0, -1, 0, 0, 1, 1);

    // Reset while header word w2 is on the bus
    found = 0; acc = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK); #1;
      HDR_VALID = !acc; apply_hdr(1); M_TREADY = 1'b1; S_TVALID = 1'b0;
      #3;
      if (HDR_READY && !acc) acc = 1;
      if (M_TVALID && M_TDATA == 32'h4011B861) found = 1;
    end
    chk("reset_test_reached_w2", {31'b0, found}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    #3;
    chk("rst_mid_m_tvalid", {31'b0, M_TVALID}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #3;
    chk("after_rst_m_tvalid", {31'b0, M_TVALID}, 32'd0);
    chk("after_rst_hdr_ready", {31'b0, HDR_READY}, 32'd1);
    chk("after_rst_m_tdata", M_TDATA, 32'd0);
    $display("reset mid-header errors=%0d", errors);
    load_pkt1();
    run_pkt(0, 0, 0, 0, 1, 1);

    // Single-beat payload arriving after a 4-cycle gap
    load_pkt2();
    pay_data[0] = 32'hA5A5A5A5; pay_keep[0] = 4'b1000; pay_n = 1;
    build_exp();
    run_pkt(0, 4, 0, 0, 2, 2);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("idle_after_pkt_m_tvalid", {31'b0, M_TVALID}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ipv4_header_inserter.md
Name: ipv4_header_inserter

Overview:
- Sits directly downstream of the IPv4 checksum calculator, in the accelerator TX path.
- Accepts one set of IPv4 header fields per packet over a valid/ready handshake and registers the computed header checksum.
- Emits the 20-byte header as five 32-bit stream beats, then passes the packet payload through unchanged until its last beat.

Parameters:
- DATA_WIDTH, 32, stream data width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width; localparam, not overridable.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- HDR_VALID  in  1  header fields valid.
- HDR_READY  out  1  block can accept header fields.
- VERSION  in  8  version/IHL byte, e.g. 0x45.
- SERVICE_TYPE  in  8  TOS byte.
- LENGTH  in  16  IPv4 total length.
- IDENTIFICATION  in  16  ID field.
- FLAGS_AND_FRAGMENT  in  16  flags and fragment offset.
- TTL  in  8  time to live.
- PROTOCOL  in  8  protocol number.
- SRC_IP_ADDRESS  in  32  source address.
- DST_IP_ADDRESS  in  32  destination address.
- S_TVALID  in  1  payload beat valid.
- S_TREADY  out  1  payload beat accepted.
- S_TDATA  in  DATA_WIDTH  payload data, first byte in [31:24].
- S_TKEEP  in  KEEP_WIDTH  payload byte enables.
- S_TLAST  in  1  last payload beat.
- M_TVALID  out  1  output beat valid.
- M_TREADY  in  1  downstream ready.
- M_TDATA  out  DATA_WIDTH  output data.
- M_TKEEP  out  KEEP_WIDTH  output byte enables.
- M_TLAST  out  1  last output beat.

Behaviour:
- Reset values: HDR_READY=0 during reset and 1 on the first cycle after it. S_TREADY=0. M_TVALID=0, M_TLAST=0, M_TKEEP=0, M_TDATA=0. State=IDLE.
- Reset mid-packet: return to IDLE at once. The partial packet is dropped and no further beats are emitted.
- FSM state IDLE:
  - HDR_READY=1.
  - On HDR_VALID&&HDR_READY, register all header fields and go to CSUM.
- FSM state CSUM:
  - Lasts exactly 1 cycle.
  - Register CHECKSUM from the combinational calculator driven by the registered fields.
  - Go to HDR with word index=0.
- FSM state HDR:
  - M_TVALID=1, M_TKEEP=4'hF, M_TLAST=0.
  - Words in order, first byte in [31:24]:
    - w0 = {VERSION, SERVICE_TYPE, LENGTH}
    - w1 = {IDENTIFICATION, FLAGS_AND_FRAGMENT}
    - w2 = {TTL, PROTOCOL, CHECKSUM}
    - w3 = SRC_IP_ADDRESS
    - w4 = DST_IP_ADDRESS
  - Index advances only on M_TVALID&&M_TREADY.
  - After w4 is accepted, go to PAYLOAD.
- FSM state PAYLOAD:
  - Combinational pass-through: M_TVALID=S_TVALID, S_TREADY=M_TREADY, M_TDATA/M_TKEEP/M_TLAST = S_TDATA/S_TKEEP/S_TLAST.
  - When a beat with S_TLAST=1 is transferred, go to IDLE.
- S_TREADY is 0 in every state except PAYLOAD. Payload is never consumed before the header completes.
- Backpressure: while M_TVALID=1 and M_TREADY=0, M_TDATA, M_TKEEP and M_TLAST hold stable.
- Latency: the first header beat is presented 2 cycles after header acceptance (accept edge, then CSUM).
- Minimum per-packet overhead: 1 IDLE cycle + 1 CSUM cycle + 5 header beats.
- Back-to-back packets: HDR_READY reasserts on the cycle after the last payload beat transfers. No header fields are accepted while a packet is in flight.
- The block does not check LENGTH against the actual payload. Every packet must carry at least one payload beat.
- Checksum arithmetic is the one's-complement sum defined by the calculator. The inserter does not recompute or modify it.

Decomposition:
- Shared package: FSM state enum (IDLE, CSUM, HDR, PAYLOAD), localparam IPV4_HDR_WORDS=5, a packed struct for the IPv4 header fields.
- One sub-module instance: ipv4_checksum_calculator, fed from the registered header fields.
- Word selection and the payload mux stay in this module.

Test Plan:
- Header VERSION=0x45, SERVICE_TYPE=0x00, LENGTH=0x0073, IDENTIFICATION=0x0000, FLAGS_AND_FRAGMENT=0x4000, TTL=0x40, PROTOCOL=0x11, SRC=0xC0A80001, DST=0xC0A800C7; payload of 3 beats, last TKEEP=4'b1100; M_TREADY=1 -> output is 45000073, 00004000, 4011B861, C0A80001, C0A800C7, then the payload unchanged with TLAST on beat 8 only.
- Same packet with M_TREADY toggling 1/0 every cycle -> identical beat sequence, data stable during stalls, no beats lost or duplicated.
- Two packets with HDR_VALID held high continuously -> second header accepted only on the cycle after packet 1's TLAST transfer; HDR_READY=0 in between.
- S_TVALID=1 asserted during IDLE/CSUM/HDR -> S_TREADY=0 throughout, and the payload's first beat appears right after w4.
- RESET asserted during header word w2 -> next cycle M_TVALID=0 and state IDLE; a fresh packet then emits correctly from w0.
- Single-beat payload with S_TLAST=1 and S_TVALID=0 for 4 cycles before it -> M_TVALID=0 during the gap, exactly 6 output beats total.
